// File: rtl/frame_align_ctrl.sv
// Word-alignment controller for an ISERDES LVDS receiver: bitslips the frame and data
// deserialisers until the frame word matches FRAME_PATTERN, then supervises lock.
module frame_align_ctrl #(
  parameter int             S             = 8,
  parameter int             N_CH          = 1,
  parameter logic [S-1:0]   FRAME_PATTERN = 8'h0F,
  parameter int             SETTLE        = 4,
  parameter int             LOCK_CNT      = 16,
  parameter int             LOSS_CNT      = 4
) (
  input  logic                  sample_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [S-1:0]          frame_in,
  input  logic [N_CH*S-1:0]     data_in,
  output logic                  bitslip,
  output logic [N_CH*S-1:0]     data_out,
  output logic                  data_valid,
  output logic                  locked,
  output logic [$clog2(S):0]    slip_count,
  output logic                  align_err
);

  localparam int SW = $clog2(S) + 1;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam int TW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  state_t          state, state_n;
  logic [MW-1:0]   match_cnt, match_n;
  logic [LW-1:0]   loss_cnt, loss_n;
  logic [TW-1:0]   settle_cnt, settle_n;
  logic [SW-1:0]   slip_n;
  logic            err_n;
  logic            bitslip_n;
  logic            locked_n;
  logic            frame_match;

  assign frame_match = (frame_in == FRAME_PATTERN);

  always_comb begin
    state_n   = state;
    match_n   = match_cnt;
    loss_n    = loss_cnt;
    settle_n  = settle_cnt;
    slip_n    = slip_count;
    err_n     = align_err;

    unique case (state)
      ST_IDLE: begin
        match_n  = '0;
        loss_n   = '0;
        settle_n = '0;
        slip_n   = '0;
        err_n    = 1'b0;
        if (enable) state_n = ST_CHECK;
      end
      ST_CHECK: begin
        if (slip_count == SW'(S)) err_n = 1'b1;
        if (frame_match) begin
          if (match_cnt == MW'(LOCK_CNT - 1)) begin
            match_n = '0;
            state_n = ST_LOCKED;
          end else begin
            match_n = match_cnt + MW'(1);
          end
        end else begin
          match_n = '0;
          state_n = ST_SLIP;
        end
      end
      ST_SLIP: begin
        settle_n = '0;
        state_n  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt == TW'(SETTLE - 1)) begin
          settle_n = '0;
          match_n  = '0;
          state_n  = ST_CHECK;
        end else begin
          settle_n = settle_cnt + TW'(1);
        end
      end
      ST_LOCKED: begin
        if (frame_match) begin
          loss_n = '0;
        end else if (loss_cnt == LW'(LOSS_CNT - 1)) begin
          loss_n  = '0;
          state_n = ST_SLIP;
        end else begin
          loss_n = loss_cnt + LW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Dropping enable wins over everything, so a slip decided this cycle is never issued.
    if (!enable) begin
      state_n = ST_IDLE;
      err_n   = 1'b0;
    end

    if (state_n == ST_SLIP && slip_count != SW'(S)) slip_n = slip_count + SW'(1);

    bitslip_n = (state_n == ST_SLIP);
    locked_n  = (state == ST_LOCKED) && (state_n == ST_LOCKED);
  end

  always_ff @(posedge sample_clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      match_cnt  <= '0;
      loss_cnt   <= '0;
      settle_cnt <= '0;
      slip_count <= '0;
      align_err  <= 1'b0;
      bitslip    <= 1'b0;
      locked     <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      state      <= state_n;
      match_cnt  <= match_n;
      loss_cnt   <= loss_n;
      settle_cnt <= settle_n;
      slip_count <= slip_n;
      align_err  <= err_n;
      bitslip    <= bitslip_n;
      locked     <= locked_n;
      data_valid <= locked_n;
      data_out   <= data_in;
    end
  end

endmodule

// File: tb/tb_frame_align_ctrl.sv
// Scoreboard bench for frame_align_ctrl: models the ISERDES bitslip rotation and predicts
// slip/lock/error events from the alignment rules with plain cycle arithmetic.
module tb_frame_align_ctrl;

  localparam int          S        = 8;
  localparam int          N_CH     = 2;
  localparam logic [7:0]  PAT      = 8'h0F;
  localparam int          SETTLE   = 4;
  localparam int          LOCK_CNT = 16;
  localparam int          LOSS_CNT = 4;
  localparam int          PERIOD   = SETTLE + 2;

  localparam int EV_SLIP = 0;
  localparam int EV_LOCK = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic                sample_clk = 1'b0;
  logic                reset      = 1'b0;
  logic                enable     = 1'b0;
  logic [S-1:0]        frame_in   = '0;
  logic [N_CH*S-1:0]   data_in    = '0;
  logic                bitslip;
  logic [N_CH*S-1:0]   data_out;
  logic                data_valid;
  logic                locked;
  logic [$clog2(S):0]  slip_count;
  logic                align_err;

  int                  tests = 0;
  int                  failures = 0;
  int                  cyc = 0;
  int                  phase = 0;
  int                  mode = 0;
  logic                mon_en = 1'b0;
  logic [7:0]          data_cnt = '0;
  ev_t                 evq[$];
  logic [N_CH*S-1:0]   dq[$];

  frame_align_ctrl #(
    .S(S), .N_CH(N_CH), .FRAME_PATTERN(PAT), .SETTLE(SETTLE),
    .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
  ) dut (
    .sample_clk (sample_clk),
    .reset      (reset),
    .enable     (enable),
    .frame_in   (frame_in),
    .data_in    (data_in),
    .bitslip    (bitslip),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .slip_count (slip_count),
    .align_err  (align_err)
  );

  initial forever #5 sample_clk = ~sample_clk;

  initial forever begin
    @(posedge sample_clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  function automatic string kind_name(input int k);
    case (k)
      EV_SLIP: return "bitslip";
      EV_LOCK: return "lock";
      default: return "align_err";
    endcase
  endfunction

  function automatic int sat_s(input int v);
    return (v > S) ? S : v;
  endfunction

  // ISERDES model: every bitslip rotates the received frame word left by one bit.
  function automatic logic [S-1:0] frame_value();
    logic [2*S-1:0] dbl;
    dbl = {PAT, PAT} << phase;
    case (mode)
      1:       return '0;
      2:       return '1;
      default: return dbl[2*S-1:S];
    endcase
  endfunction

  function automatic void push_ev(input int kind, input int c, input int v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    evq.push_back(e);
  endfunction

  task automatic observe(input int kind, input int v);
    ev_t e;
    tests++;
    if (evq.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_%s cyc=%0d got value=%0d required no event",
               kind_name(kind), cyc, v);
    end else begin
      e = evq.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != v) begin
        failures++;
        $display("[TB] FAIL event got %s@%0d value=%0d required %s@%0d value=%0d",
                 kind_name(kind), cyc, v, kind_name(e.kind), e.cyc, e.val);
      end
    end
  endtask

  // Monitor: data path checked every cycle, control outputs checked as discrete events.
  initial begin
    logic [N_CH*S-1:0] exp;
    logic              last_reset;
    logic [1:0]        prev_lk;
    logic              prev_err;
    last_reset = 1'b0;
    prev_lk    = 2'b00;
    prev_err   = 1'b0;
    forever begin
      @(negedge sample_clk);
      if (dq.size() >= 2) begin
        exp = dq.pop_front();
        if (!last_reset) exp = '0;
        tests++;
        if (data_out !== exp) begin
          failures++;
          $display("[TB] FAIL data_out cyc=%0d got=%h required=%h", cyc, data_out, exp);
        end
      end
      last_reset = reset;
      if (mon_en) begin
        if (bitslip === 1'b1) observe(EV_SLIP, int'(slip_count));
        if ({data_valid, locked} !== prev_lk) observe(EV_LOCK, int'({data_valid, locked}));
        if (align_err !== prev_err) observe(EV_ERR, int'(align_err));
      end
      prev_lk  = {data_valid, locked};
      prev_err = align_err;
    end
  end

  task automatic apply_stimulus(input int n);
    logic sl;
    for (int i = 0; i < n; i++) begin
      @(negedge sample_clk);
      sl = bitslip;
      @(posedge sample_clk);
      #1;
      if (sl === 1'b1) phase = (phase + 1) % S;
      frame_in = frame_value();
      data_cnt = data_cnt + 8'd1;
      for (int l = 0; l < N_CH; l++) data_in[l*S +: S] = data_cnt + 8'(l * 64);
      dq.push_back(data_in);
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, req);
    end
  endtask

  task automatic check_pending(input string name);
    tests++;
    if (evq.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got %0d events missing, next %s@%0d required",
               name, cyc, evq.size(), kind_name(evq[0].kind), evq[0].cyc);
      evq.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_bitslip"},    32'(bitslip),    32'd0);
    check_output({tag, "_locked"},     32'(locked),     32'd0);
    check_output({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    check_output({tag, "_align_err"},  32'(align_err),  32'd0);
    check_output({tag, "_slip_count"}, 32'(slip_count), 32'd0);
    check_output({tag, "_data_out"},   32'(data_out),   32'd0);
  endtask

  task automatic do_reset(input int n);
    reset  = 1'b0;
    enable = 1'b0;
    mode   = 0;
    apply_stimulus(n);
    check_reset_values("reset");
  endtask

  // Starts from IDLE with a frame needing k slips; lock follows LOCK_CNT matches plus one cycle.
  task automatic run_align(input int k);
    int n0, lock_cyc;
    phase    = (S - k) % S;
    mode     = 0;
    frame_in = frame_value();
    reset    = 1'b1;
    enable   = 1'b1;
    n0       = cyc + 1;
    for (int i = 0; i < k; i++) push_ev(EV_SLIP, n0 + 1 + i * PERIOD, sat_s(i + 1));
    lock_cyc = n0 + k * PERIOD + LOCK_CNT + 1;
    push_ev(EV_LOCK, lock_cyc, 3);
    while (cyc < lock_cyc + 2) apply_stimulus(1);
    check_pending("align_events");
    check_output("align_slip_count", 32'(slip_count), 32'(k));
    check_output("align_err_clear",  32'(align_err),  32'd0);
    check_output("align_locked",     32'(locked),     32'd1);
  endtask

  task automatic run_enable_off();
    enable = 1'b0;
    push_ev(EV_LOCK, cyc + 1, 0);
    apply_stimulus(10);
    check_pending("disable_events");
    check_output("idle_slip_count", 32'(slip_count), 32'd0);
    check_output("idle_locked",     32'(locked),     32'd0);
  endtask

  task automatic run_loss(input int k, input int rounds);
    int c0;
    for (int r = 0; r < rounds; r++) begin
      mode = 1;
      apply_stimulus(LOSS_CNT - 1);
      mode = 0;
      apply_stimulus(1);
    end
    check_output("loss_hold_locked", 32'(locked), 32'd1);
    mode = 1;
    c0   = cyc;
    push_ev(EV_SLIP, c0 + LOSS_CNT + 1, sat_s(k + 1));
    push_ev(EV_LOCK, c0 + LOSS_CNT + 1, 0);
    apply_stimulus(LOSS_CNT + 2);
    enable = 1'b0;
    apply_stimulus(PERIOD + 2);
    check_pending("loss_events");
    check_output("loss_idle_slip_count", 32'(slip_count), 32'd0);
    check_output("loss_idle_bitslip",    32'(bitslip),    32'd0);
    mode = 0;
  endtask

  // Frame never matches: slips continue forever, the count saturates and align_err latches.
  task automatic run_never(input int pulses);
    int n0, err_cyc, t, tp;
    bit err_done;
    mode     = 2;
    frame_in = frame_value();
    reset    = 1'b1;
    enable   = 1'b1;
    n0       = cyc + 1;
    err_cyc  = n0 + S * PERIOD + 1;
    err_done = 0;
    for (int i = 0; i < pulses; i++) begin
      t = n0 + 1 + i * PERIOD;
      if (!err_done && err_cyc < t) begin
        push_ev(EV_ERR, err_cyc, 1);
        err_done = 1;
      end
      push_ev(EV_SLIP, t, sat_s(i + 1));
      if (!err_done && err_cyc == t) begin
        push_ev(EV_ERR, err_cyc, 1);
        err_done = 1;
      end
    end
    tp = n0 + 1 + (pulses - 1) * PERIOD;
    while (cyc < tp + 1) apply_stimulus(1);
    check_output("never_slip_sat",  32'(slip_count), 32'(S));
    check_output("never_align_err", 32'(align_err),  32'd1);
    reset = 1'b0;
    push_ev(EV_ERR, tp + 2, 0);
    apply_stimulus(1);
    check_reset_values("settle_reset");
    apply_stimulus(2 * PERIOD);
    check_pending("never_events");
  endtask

  initial begin
    int k;
    data_cnt = 8'($urandom_range(0, 255));
    do_reset(4);
    mon_en = 1'b1;

    run_align(0);
    run_enable_off();
    run_align(0);
    run_loss(0, 2);

    do_reset(3);
    run_align(7);
    run_enable_off();

    for (int t = 0; t < 3; t++) begin
      do_reset(3);
      k = $urandom_range(0, S - 1);
      run_align(k);
      run_loss(k, $urandom_range(1, 3));
    end

    do_reset(3);
    run_never(S + 1 + $urandom_range(0, 3));
    do_reset(3);
    check_pending("final_events");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/frame_align_ctrl.md
Name: frame_align_ctrl

Overview:
- Automatic word-alignment controller for the Spartan-6 ISERDES LVDS receiver; runs in the `sample_clk` domain.
- Compares the deserialised frame-clock word against a programmable frame pattern. Issues single-cycle bitslip pulses to the frame and data ISERDES until the pattern matches, then declares lock.
- Registers N_CH data lanes to `data_out`, qualified by `data_valid`.
- Supervises lock continuously: drops lock and re-acquires when the frame word is lost.

Parameters:
- S, 8, deserialisation factor (bits per word per lane).
- N_CH, 1, number of data lanes sharing the frame clock.
- FRAME_PATTERN, 8'h0F, expected frame word when aligned; width S.
- SETTLE, 4, cycles to wait after a bitslip pulse before comparing; must be >= 1.
- LOCK_CNT, 16, consecutive matches required to declare lock; must be >= 1.
- LOSS_CNT, 4, consecutive mismatches while locked that drop lock; must be >= 1.

Ports:
- sample_clk  in  1  word clock; all logic on its rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- enable  in  1  1 = run alignment; 0 = hold in IDLE.
- frame_in  in  S  deserialised frame-clock word.
- data_in  in  N_CH*S  deserialised data lanes, lane k at bits [k*S +: S].
- bitslip  out  1  one-cycle bitslip pulse to all ISERDES.
- data_out  out  N_CH*S  data_in registered once.
- data_valid  out  1  equals locked, aligned with data_out.
- locked  out  1  alignment achieved.
- slip_count  out  clog2(S)+1  bitslips issued since the last IDLE exit; saturates at S.
- align_err  out  1  sticky: S slips issued without reaching lock.

Behaviour:
- Reset (reset=0 at a clock edge) forces these values at the next edge, overriding all other inputs:
  - state=IDLE
  - bitslip=0, locked=0, data_valid=0, align_err=0, slip_count=0, data_out=0
  - all internal counters=0
- States and transitions:
  - IDLE: counters cleared. Moves to CHECK when enable=1.
  - CHECK: each cycle, compares frame_in to FRAME_PATTERN.
    - On a match, the match counter increments. When it reaches LOCK_CNT, go to LOCKED and assert locked on the next cycle.
    - Any mismatch clears the match counter and goes to SLIP.
  - SLIP: bitslip=1 for exactly this one cycle; slip_count increments, saturating at S. Then go to SETTLE.
  - SETTLE: waits SETTLE cycles with bitslip=0, then returns to CHECK with the match counter at 0.
  - Error: if slip_count reaches S while in CHECK with no lock, set align_err. Slipping continues and slip_count stays at S. align_err clears only on reset or on the IDLE transition.
  - LOCKED: locked=1.
    - Each mismatch increments the loss counter; each match clears it.
    - When the loss counter reaches LOSS_CNT, locked=0 on the next cycle, the state goes to SLIP, and slip_count is preserved.
- bitslip is never asserted in consecutive cycles. The minimum spacing between pulses is SETTLE+2 cycles.
- enable=0 in any state moves to IDLE on the next edge:
  - locked=0 and bitslip=0.
  - A pending SLIP pulse is not issued.
- data_out <= data_in every cycle, unconditionally (1-cycle latency).
- data_valid <= locked, registered, so it has the same timing as locked.
- Comparison is exact, over all S bits; there are no wildcard bits.
- All counters are sized for their terminal values, so none wraps.

Test Plan:
1. Aligned input: S=8, frame_in=8'h0F constant, enable=1 after reset.
   - bitslip never pulses.
   - locked=1 exactly LOCK_CNT+1 cycles after leaving IDLE.
   - slip_count=0, align_err=0.
2. Rotated frame: bench models the ISERDES; each bitslip rotates frame_in by one bit; start at 8'h1E (needs 7 slips to reach 0x0F).
   - Exactly 7 single-cycle pulses, spaced >= SETTLE+2.
   - slip_count=7, then locked=1.
   - data_valid follows locked.
3. Never-matching frame: frame_in=8'hFF.
   - align_err=1 once slip_count=8.
   - slip_count holds at 8; pulses continue; locked stays 0.
4. Loss of lock: after lock, force 3 mismatches then 1 match, repeated.
   - locked stays 1.
   - Then force 4 consecutive mismatches: locked=0 the following cycle and one bitslip pulse follows.
5. Reset and enable mid-operation:
   - reset=0 asserted during SETTLE: at the next edge all outputs take their reset values and no further bitslip occurs.
   - enable=0 while locked: locked=0 next cycle; the state machine sits in IDLE until enable returns.
6. Multi-lane: N_CH=2, data_in lanes driven with an incrementing count.
   - data_out equals data_in delayed by exactly 1 cycle on both lanes.
   - Lane order is preserved.
